// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Contents:
//   fetch_state_t   FSM encoding (S_IDLE, S_REQ, S_VALID, S_HALT)
//   RESET_PC_DEF    default reset / first fetch address
//   TGT_MSB/LSB     jump target field slice of an instruction word
//   IMM_MSB/LSB     branch immediate field slice of an instruction word
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

   localparam int TGT_MSB = 25;
   localparam int TGT_LSB = 0;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection for the fetch stage
//
// Ports:
//   pc_plus4     in  32  address of the instruction after the current one
//   instr_out    in  32  current instruction (target / immediate source)
//   Jump         in  1   J/JAL
//   Branch       in  1   BEQ/BNE
//   branch_cond  in  1   branch resolved as taken
//   JumpReg      in  1   JR
//   jr_target    in  32  register value for JR
//   next_pc      out 32  selected next PC (JumpReg > Jump > taken branch > pc_plus4)
module next_pc_calc
   import mips_fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr_out,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        branch_cond,
   input  logic        JumpReg,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc
);

   logic [31:0] jump_target;
   logic [31:0] branch_offset;
   logic        unused_opcode;

   assign jump_target   = {pc_plus4[31:28], instr_out[TGT_MSB:TGT_LSB], 2'b00};
   // Sign-extended word offset, already shifted to a byte offset.
   assign branch_offset = {{14{instr_out[IMM_MSB]}}, instr_out[IMM_MSB:IMM_LSB], 2'b00};
   assign unused_opcode = ^instr_out[31:26];

   always_comb begin
      next_pc = pc_plus4;
      if (JumpReg)
         next_pc = jr_target;
      else if (Jump)
         next_pc = jump_target;
      else if (Branch && branch_cond)
         next_pc = pc_plus4 + branch_offset;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, imem handshake, next-PC update
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds misaligned output and a halt state).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/imem_addr      fetch request and address (address equals pc_out)
//   imem_rdata/imem_ready   memory response word and strobe
//   stall                   decoder holds the current instruction
//   Jump/Branch/JumpReg     decoder control, used only when an instruction is accepted
//   branch_cond, jr_target  datapath branch outcome and JR register value
//   instr_out/instr_valid   instruction presented to the decoder
//   pc_out/pc_plus4         address of instr_out and its link value
//   misaligned              (FETCH_ALIGN_CHECK_EN only) sticky misaligned-target flag
module fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        branch_cond,
   input  logic        JumpReg,
   input  logic [31:0] jr_target,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic [31:0] pc_out,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        misaligned,
`endif
   output logic [31:0] pc_plus4
);

   fetch_state_t state;
   logic [31:0]  next_pc;

   assign pc_plus4  = pc_out + 32'd4;
   assign imem_addr = pc_out;

   next_pc_calc u_next_pc (
      .pc_plus4    (pc_plus4),
      .instr_out   (instr_out),
      .Jump        (Jump),
      .Branch      (Branch),
      .branch_cond (branch_cond),
      .JumpReg     (JumpReg),
      .jr_target   (jr_target),
      .next_pc     (next_pc)
   );

   // imem_req and instr_valid are registered alongside the state so they
   // change only on clock edges (and drop immediately on reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc_out      <= RESET_PC;
         instr_out   <= 32'd0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         misaligned  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
            S_REQ: begin
               if (imem_ready) begin
                  instr_out   <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= S_VALID;
               end
            end
            S_VALID: begin
               if (!stall) begin
                  instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                  if (next_pc[1:0] != 2'b00) begin
                     misaligned <= 1'b1;
                     state      <= S_HALT;
                  end else begin
                     pc_out   <= next_pc;
                     imem_req <= 1'b1;
                     state    <= S_REQ;
                  end
`else
                  pc_out   <= next_pc & ~32'd3;
                  imem_req <= 1'b1;
                  state    <= S_REQ;
`endif
               end
            end
            default: begin
               // Terminal until reset.
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        Jump;
   logic        Branch;
   logic        branch_cond;
   logic        JumpReg;
   logic [31:0] jr_target;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misaligned;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .stall       (stall),
      .Jump        (Jump),
      .Branch      (Branch),
      .branch_cond (branch_cond),
      .JumpReg     (JumpReg),
      .jr_target   (jr_target),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
`ifdef FETCH_ALIGN_CHECK_EN
      .misaligned  (misaligned),
`endif
      .pc_plus4    (pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_ctrl();
      Jump = 0; Branch = 0; branch_cond = 0; JumpReg = 0; jr_target = 32'd0;
   endtask

   // Called in S_REQ at a negedge; leaves the DUT in S_VALID.
   task automatic do_fetch(input logic [31:0] word);
      stall = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = word;
      cyc();
      imem_ready = 1'b0;
   endtask

   // Called in S_VALID; accepts with the given control and leaves the DUT in S_REQ.
   task automatic do_accept(input logic j, input logic b, input logic bc,
                            input logic jr, input logic [31:0] jrt);
      Jump = j; Branch = b; branch_cond = bc; JumpReg = jr; jr_target = jrt;
      stall = 1'b0;
      cyc();
      clr_ctrl();
      stall = 1'b1;
   endtask

   task automatic seq_steps(input int n);
      for (int i = 0; i < n; i++) begin
         do_fetch(32'h0000_0000);
         do_accept(0, 0, 0, 0, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
      clr_ctrl();
      repeat (2) cyc();
      check("rst_req",   {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_pc",    pc_out, 32'h0040_0000);
      check("rst_instr", instr_out, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rst_misal", {31'd0, misaligned}, 32'd0);
`endif

      // Reset release, one idle cycle, then first request.
      rst_n = 1'b1;
      check("idle_req", {31'd0, imem_req}, 32'd0);
      cyc();
      check("req1",      {31'd0, imem_req}, 32'd1);
      check("req1_addr", imem_addr, 32'h0040_0000);
      check("req1_val",  {31'd0, instr_valid}, 32'd0);
      imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
      cyc();
      imem_ready = 1'b0;
      check("valid_at2", {31'd0, instr_valid}, 32'd1);
      check("instr1",    instr_out, 32'h2008_0005);
      check("req_off",   {31'd0, imem_req}, 32'd0);
      check("plus4",     pc_plus4, 32'h0040_0004);
      cyc();
      check("seq_addr", imem_addr, 32'h0040_0004);
      check("seq_req",  {31'd0, imem_req}, 32'd1);

      // Memory wait of 4 cycles, then a 3-cycle stall.
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("wait_req",  {31'd0, imem_req}, 32'd1);
         check("wait_addr", imem_addr, 32'h0040_0004);
      end
      stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
      cyc();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_instr", instr_out, 32'h1234_5678);
         check("stall_pc",    pc_out, 32'h0040_0004);
         check("stall_req",   {31'd0, imem_req}, 32'd0);
         check("stall_val",   {31'd0, instr_valid}, 32'd1);
         cyc();
      end
      stall = 1'b0;
      cyc();
      stall = 1'b1;
      check("post_stall_addr", imem_addr, 32'h0040_0008);
      check("post_stall_req",  {31'd0, imem_req}, 32'd1);

      // Asynchronous reset mid-fetch, late ready across release.
      #2 rst_n = 1'b0;
      #1;
      check("async_req", {31'd0, imem_req}, 32'd0);
      check("async_pc",  pc_out, 32'h0040_0000);
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      check("late_rdy_val",   {31'd0, instr_valid}, 32'd0);
      check("late_rdy_instr", instr_out, 32'd0);
      check("late_rdy_req",   {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b0;

      // Walk to 0x0040_0010 and take a backward branch.
      do_accept(0, 0, 0, 0, 32'd0);
      seq_steps(4);
      check("pc_10", pc_out, 32'h0040_0010);
      do_fetch(32'h1000_FFFC);
      do_accept(0, 1, 1, 0, 32'd0);
      check("br_taken", imem_addr, 32'h0040_0004);
      seq_steps(3);
      do_fetch(32'h1000_FFFC);
      do_accept(0, 1, 0, 0, 32'd0);
      check("br_not_taken", imem_addr, 32'h0040_0014);

      // Jump, then Jump with JumpReg.
      seq_steps(3);
      check("pc_20", pc_out, 32'h0040_0020);
      do_fetch(32'h0810_0010);
      do_accept(1, 0, 0, 0, 32'd0);
      check("jump", imem_addr, 32'h0040_0040);
      do_fetch(32'h0810_0010);
      do_accept(1, 0, 0, 1, 32'h0040_0100);
      check("jr_prio", imem_addr, 32'h0040_0100);

      // pc_plus4 wraps at the top of the address space.
      do_fetch(32'd0);
      do_accept(0, 0, 0, 1, 32'hFFFF_FFFC);
      check("wrap_pc", pc_out, 32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4, 32'd0);
      do_fetch(32'd0);
      do_accept(0, 0, 0, 1, 32'h0040_0100);

      // Misaligned JR target.
      do_fetch(32'd0);
      do_accept(0, 0, 0, 1, 32'h0040_0102);
`ifdef FETCH_ALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         check("misal_flag", {31'd0, misaligned}, 32'd1);
         check("misal_pc",   pc_out, 32'h0040_0100);
         check("misal_req",  {31'd0, imem_req}, 32'd0);
         check("misal_val",  {31'd0, instr_valid}, 32'd0);
         cyc();
      end
`else
      check("align_pc",  pc_out, 32'h0040_0100);
      check("align_req", {31'd0, imem_req}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
